// File: rtl/dual_issue_scoreboard_if.sv
// Decode-to-scoreboard pair bus: two decoded slots in, per-slot issue grants
// and the registered pending-register count out.
interface dual_issue_scoreboard_if #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 4
);
  localparam int AW = $clog2(NUM_REGS);

  logic             flush;
  logic             v0, v1;
  logic             pipe0, pipe1;
  logic             we0, we1;
  logic [AW-1:0]    rt0, rt1;
  logic [AW-1:0]    ra0, rb0, rc0;
  logic [AW-1:0]    ra1, rb1, rc1;
  logic [2:0]       sen0, sen1;
  logic [LAT_W-1:0] lat0, lat1;
  logic             issue0, issue1;
  logic [7:0]       pending;

  modport master (
    output flush, v0, v1, pipe0, pipe1, we0, we1, rt0, rt1,
           ra0, rb0, rc0, ra1, rb1, rc1, sen0, sen1, lat0, lat1,
    input  issue0, issue1, pending
  );

  modport slave (
    input  flush, v0, v1, pipe0, pipe1, we0, we1, rt0, rt1,
           ra0, rb0, rc0, ra1, rb1, rc1, sen0, sen1, lat0, lat1,
    output issue0, issue1, pending
  );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// Dual-issue SPU scoreboard: per-register latency countdown, RAW/WAW/pipe/intra-pair
// issue gating. Define SCB_FORWARD_EN to relax the RAW ready threshold to cnt <= 1.
module dual_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  dual_issue_scoreboard_if.slave   bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int PW = 8;

  logic [LAT_W-1:0] r_cnt     [NUM_REGS];
  logic [LAT_W-1:0] w_cnt_nxt [NUM_REGS];
  logic [PW-1:0]    r_pending;
  logic [PW-1:0]    w_pend_nxt;

  logic [LAT_W-1:0] w_l0, w_l1;
  logic             w_raw0, w_waw0, w_raw1, w_waw1;
  logic             w_pair_raw, w_pair_waw;
  logic             w_issue0, w_issue1;

  // A source still counting down above the threshold is not yet readable.
  function automatic logic not_ready(input logic [LAT_W-1:0] c);
`ifdef SCB_FORWARD_EN
    return c > LAT_W'(1);
`else
    return c != '0;
`endif
  endfunction

  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] l);
    return (l == '0) ? LAT_W'(1) : l;
  endfunction

  assign w_l0 = eff_lat(bus.lat0);
  assign w_l1 = eff_lat(bus.lat1);

  assign w_raw0 = (bus.sen0[0] & not_ready(r_cnt[bus.ra0])) |
                  (bus.sen0[1] & not_ready(r_cnt[bus.rb0])) |
                  (bus.sen0[2] & not_ready(r_cnt[bus.rc0]));
  assign w_waw0 = bus.we0 & (r_cnt[bus.rt0] >= w_l0);

  assign w_raw1 = (bus.sen1[0] & not_ready(r_cnt[bus.ra1])) |
                  (bus.sen1[1] & not_ready(r_cnt[bus.rb1])) |
                  (bus.sen1[2] & not_ready(r_cnt[bus.rc1]));
  assign w_waw1 = bus.we1 & (r_cnt[bus.rt1] >= w_l1);

  // Slot 1 cannot see slot 0's result in the same cycle, so any overlap blocks it.
  assign w_pair_raw = bus.we0 & ((bus.sen1[0] & (bus.ra1 == bus.rt0)) |
                                 (bus.sen1[1] & (bus.rb1 == bus.rt0)) |
                                 (bus.sen1[2] & (bus.rc1 == bus.rt0)));
  assign w_pair_waw = bus.we0 & bus.we1 & (bus.rt0 == bus.rt1);

  assign w_issue0 = bus.v0 & ~bus.flush & ~reset & ~w_raw0 & ~w_waw0;
  assign w_issue1 = w_issue0 & bus.v1 & (bus.pipe1 != bus.pipe0) &
                    ~w_raw1 & ~w_waw1 & ~w_pair_raw & ~w_pair_waw;

  assign bus.issue0  = w_issue0;
  assign bus.issue1  = w_issue1;
  assign bus.pending = r_pending;

  // Next-state countdown: flush, then issue load, then decrement.
  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (bus.flush) begin
        w_cnt_nxt[i] = '0;
      end else if (w_issue0 && bus.we0 && (bus.rt0 == AW'(i))) begin
        w_cnt_nxt[i] = w_l0 - LAT_W'(1);
      end else if (w_issue1 && bus.we1 && (bus.rt1 == AW'(i))) begin
        w_cnt_nxt[i] = w_l1 - LAT_W'(1);
      end else if (r_cnt[i] != '0) begin
        w_cnt_nxt[i] = r_cnt[i] - LAT_W'(1);
      end
      if (w_cnt_nxt[i] != '0) begin
        w_pend_nxt = w_pend_nxt + PW'(1);
      end
    end
  end

  // Stage boundary: counter file and pending count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_pending <= w_pend_nxt;
    end
  end
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed table-driven bench for dual_issue_scoreboard plus hand sequences for
// flush, asynchronous reset mid-countdown and maximum-latency countdown.
module tb_dual_issue_scoreboard;
`ifdef SCB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic       fl, v0, v1, p0, p1, we0, we1;
    logic [6:0] rt0, ra0, rb0, rc0, rt1, ra1, rb1, rc1;
    logic [2:0] sen0, sen1;
    logic [3:0] lat0, lat1;
    logic       e0, e1;
    logic [7:0] ep;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  vec_t tv[$];
  vec_t v;

  always #5 clk = ~clk;

  dual_issue_scoreboard_if bus ();

  dual_issue_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic vec_t idle(input logic [7:0] ep);
    vec_t r;
    r.fl = 0; r.v0 = 0; r.v1 = 0; r.p0 = 0; r.p1 = 0; r.we0 = 0; r.we1 = 0;
    r.rt0 = 0; r.ra0 = 0; r.rb0 = 0; r.rc0 = 0;
    r.rt1 = 0; r.ra1 = 0; r.rb1 = 0; r.rc1 = 0;
    r.sen0 = 0; r.sen1 = 0; r.lat0 = 0; r.lat1 = 0;
    r.e0 = 0; r.e1 = 0; r.ep = ep;
    return r;
  endfunction

  function automatic vec_t s0(input logic we, input logic [6:0] rt, input logic [2:0] sen,
                              input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                              input logic [3:0] lat, input logic pipe);
    vec_t r = idle(0);
    r.v0 = 1; r.we0 = we; r.rt0 = rt; r.sen0 = sen;
    r.ra0 = ra; r.rb0 = rb; r.rc0 = rc; r.lat0 = lat; r.p0 = pipe;
    return r;
  endfunction

  function automatic vec_t with1(input vec_t b, input logic we, input logic [6:0] rt,
                                 input logic [2:0] sen, input logic [6:0] ra,
                                 input logic [6:0] rb, input logic [6:0] rc,
                                 input logic [3:0] lat, input logic pipe);
    vec_t r = b;
    r.v1 = 1; r.we1 = we; r.rt1 = rt; r.sen1 = sen;
    r.ra1 = ra; r.rb1 = rb; r.rc1 = rc; r.lat1 = lat; r.p1 = pipe;
    return r;
  endfunction

  function automatic vec_t ex(input vec_t b, input logic e0, input logic e1, input logic [7:0] ep);
    vec_t r = b;
    r.e0 = e0; r.e1 = e1; r.ep = ep;
    return r;
  endfunction

  function automatic vec_t fl_on(input vec_t b);
    vec_t r = b;
    r.fl = 1;
    return r;
  endfunction

  task automatic drive(input vec_t d);
    bus.flush = d.fl;
    bus.v0 = d.v0; bus.v1 = d.v1; bus.pipe0 = d.p0; bus.pipe1 = d.p1;
    bus.we0 = d.we0; bus.we1 = d.we1;
    bus.rt0 = d.rt0; bus.ra0 = d.ra0; bus.rb0 = d.rb0; bus.rc0 = d.rc0;
    bus.rt1 = d.rt1; bus.ra1 = d.ra1; bus.rb1 = d.rb1; bus.rc1 = d.rc1;
    bus.sen0 = d.sen0; bus.sen1 = d.sen1; bus.lat0 = d.lat0; bus.lat1 = d.lat1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    // Stimulus table, one entry per clock cycle.
    tv.push_back(ex(s0(1, 1, 0, 0, 0, 0, 2, 0), 1, 0, 0));
    tv.push_back(idle(1));
    tv.push_back(idle(0));
    tv.push_back(ex(s0(1, 2, 0, 0, 0, 0, 4, 0), 1, 0, 0));
    tv.push_back(ex(s0(1, 20, 3'b001, 2, 0, 0, 2, 0), 0, 0, 1));
    tv.push_back(ex(s0(1, 20, 3'b001, 2, 0, 0, 2, 0), 0, 0, 1));
    tv.push_back(ex(s0(1, 20, 3'b001, 2, 0, 0, 2, 0), FWD, 0, 1));
    tv.push_back(ex(s0(1, 20, 3'b001, 2, 0, 0, 2, 0), 1, 0, {7'd0, FWD}));
    tv.push_back(idle(1));
    tv.push_back(ex(with1(s0(1, 3, 3'b001, 10, 0, 0, 2, 0), 0, 0, 3'b111, 11, 12, 3, 1, 1), 1, 0, 0));
    tv.push_back(ex(with1(s0(1, 4, 3'b001, 10, 0, 0, 2, 0), 0, 0, 3'b111, 11, 12, 5, 1, 1), 1, 1, 1));
    tv.push_back(ex(with1(s0(1, 6, 0, 0, 0, 0, 1, 0), 1, 7, 0, 0, 0, 0, 1, 0), 1, 0, 1));
    tv.push_back(ex(s0(1, 8, 3'b001, 6, 0, 0, 3, 0), 1, 0, 0));
    tv.push_back(ex(with1(s0(0, 0, 3'b001, 8, 0, 0, 1, 0), 0, 0, 0, 0, 0, 0, 1, 1), 0, 0, 1));
    tv.push_back(ex(with1(s0(1, 9, 0, 0, 0, 0, 0, 0), 0, 0, 3'b010, 0, 9, 0, 1, 1), 1, 0, 1));
    tv.push_back(ex(with1(s0(1, 10, 0, 0, 0, 0, 3, 0), 1, 10, 0, 0, 0, 0, 1, 1), 1, 0, 0));
    tv.push_back(ex(with1(s0(0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 3'b001, 10, 0, 0, 1, 1), 1, 0, 1));
    tv.push_back(ex(with1(s0(0, 0, 0, 0, 0, 0, 1, 0), 1, 10, 0, 0, 0, 0, 1, 1), 1, 0, 1));
    tv.push_back(ex(with1(idle(0), 0, 0, 0, 0, 0, 0, 1, 1), 0, 0, 0));
    tv.push_back(ex(with1(s0(1, 0, 0, 0, 0, 0, 5, 0), 1, 127, 0, 0, 0, 0, 15, 1), 1, 1, 0));
    tv.push_back(fl_on(ex(s0(0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 2)));
    tv.push_back(ex(with1(s0(0, 0, 3'b001, 127, 0, 0, 1, 0), 0, 0, 3'b001, 0, 0, 0, 1, 1), 1, 1, 0));
    tv.push_back(ex(s0(1, 5, 0, 0, 0, 0, 6, 0), 1, 0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(ex(s0(1, 5, 0, 0, 0, 0, 2, 0), 0, 0, 1));
    tv.push_back(ex(s0(1, 5, 0, 0, 0, 0, 2, 0), 1, 0, 1));
    tv.push_back(idle(1));
    tv.push_back(idle(0));

    // Reset state: nothing issues while reset is high.
    reset = 1'b1;
    drive(s0(0, 0, 0, 0, 0, 0, 1, 0));
    #2;
    chk("reset_issue0", 0, {7'd0, bus.issue0}, 0);
    chk("reset_pending", 0, bus.pending, 0);
    @(posedge clk); #1;
    chk("reset_issue0_hold", 0, {7'd0, bus.issue0}, 0);
    drive(idle(0));
    @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) begin
      @(posedge clk); #1;
      drive(tv[i]);
      @(negedge clk);
      chk("issue0", i, {7'd0, bus.issue0}, {7'd0, tv[i].e0});
      chk("issue1", i, {7'd0, bus.issue1}, {7'd0, tv[i].e1});
      chk("pending", i, bus.pending, tv[i].ep);
    end

    // Flush while r12 is counting down.
    @(posedge clk); #1;
    drive(s0(1, 12, 0, 0, 0, 0, 4, 0));
    @(negedge clk);
    chk("flush_writer", 0, {7'd0, bus.issue0}, 1);
    @(posedge clk); #1;
    drive(fl_on(s0(0, 0, 3'b001, 12, 0, 0, 1, 0)));
    @(negedge clk);
    chk("flush_issue0", 0, {7'd0, bus.issue0}, 0);
    chk("flush_pend_before", 0, bus.pending, 1);
    @(posedge clk); #1;
    drive(s0(0, 0, 3'b001, 12, 0, 0, 1, 0));
    @(negedge clk);
    chk("flush_pend_after", 0, bus.pending, 0);
    chk("flush_dep_issue", 0, {7'd0, bus.issue0}, 1);

    // Asynchronous reset mid-countdown on r12.
    @(posedge clk); #1;
    drive(s0(1, 12, 0, 0, 0, 0, 4, 0));
    @(negedge clk);
    chk("rst_writer", 0, {7'd0, bus.issue0}, 1);
    @(posedge clk); #1;
    drive(s0(0, 0, 3'b001, 12, 0, 0, 1, 0));
    @(negedge clk);
    chk("rst_dep_blocked", 0, {7'd0, bus.issue0}, 0);
    chk("rst_pend_before", 0, bus.pending, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_pend_async", 0, bus.pending, 0);
    chk("rst_issue0_high", 0, {7'd0, bus.issue0}, 0);
    @(posedge clk); #1;
    chk("rst_issue0_edge", 0, {7'd0, bus.issue0}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_dep_issue", 0, {7'd0, bus.issue0}, 1);
    chk("rst_pend_after", 0, bus.pending, 0);

    // Maximum latency: counter starts at 14 and stops at 0 without wrapping.
    @(posedge clk); #1;
    drive(s0(1, 100, 0, 0, 0, 0, 15, 0));
    @(negedge clk);
    chk("sat_writer", 0, {7'd0, bus.issue0}, 1);
    for (int k = 1; k <= 16; k++) begin
      int c;
      c = (k < 15) ? 15 - k : 0;
      @(posedge clk); #1;
      drive(s0(0, 0, 3'b001, 100, 0, 0, 1, 0));
      @(negedge clk);
      chk("sat_pending", k, bus.pending, (c != 0) ? 8'd1 : 8'd0);
      chk("sat_dep_issue", k, {7'd0, bus.issue0}, FWD ? {7'd0, c <= 1} : {7'd0, c == 0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
